// File: rtl/mux_onehot_pipe_pkg.sv
// Shared router package: one-hot grant helpers and skid-buffer occupancy encoding.
package mux_onehot_pipe_pkg;

    // Widest grant vector the helpers accept; callers zero-extend narrower grants.
    localparam int ONEHOT_MAX_WIDTH = 64;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b11
    } buf_state_e;

    // Zero or one bit set: clearing the lowest set bit must leave nothing behind.
    function automatic logic onehot_legal(input logic [ONEHOT_MAX_WIDTH-1:0] vec);
        return (vec & (vec - ONEHOT_MAX_WIDTH'(1))) == '0;
    endfunction

    // Exactly one bit set.
    function automatic logic onehot_exact(input logic [ONEHOT_MAX_WIDTH-1:0] vec);
        return onehot_legal(vec) && (vec != '0);
    endfunction

endpackage : mux_onehot_pipe_pkg

// File: rtl/mux_onehot_pipe_skid_buffer_2.sv
// Two-entry valid/ready buffer: 'main' drives the output, 'skid' absorbs the one
// flit that can arrive while the output stalls. Upstream ready is a pure register.
module skid_buffer_2
    import mux_onehot_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i
);

    logic                  main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                  acc;
    buf_state_e            state;

    // Upstream ready depends only on whether skid is occupied, never on out_ready_i.
    assign in_ready_o  = ~skid_valid_q;
    assign acc         = in_valid_i & in_ready_o;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

    // Next-state for both entries, driven by occupancy, accept and drain.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned
        // and no latch is inferred.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        state = buf_state_e'({skid_valid_q, main_valid_q});

        unique case (state)
            BUF_EMPTY: begin
                if (acc) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data_i;
                end
            end
            BUF_ONE: begin
                if (acc && out_ready_i) begin
                    // Accept and drain together: reload main, no bubble.
                    main_data_d = in_data_i;
                end else if (acc) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data_i;
                end else if (out_ready_i) begin
                    main_valid_d = 1'b0;
                end
            end
            BUF_FULL: begin
                // No accept possible here since in_ready_o is low.
                if (out_ready_i) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end
            end
            default: begin
                // Skid valid without main valid is unreachable; recover to EMPTY.
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase
    end

    // Control flops and the output data register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Skid payload register.
    always_ff @(posedge clk) begin
        // NOTE: skid data carries no reset; it is only observed through main after
        // skid_valid_q has been set, and skid_valid_q is reset.
        skid_data_q <= skid_data_d;
    end

endmodule : skid_buffer_2

// File: rtl/mux_onehot_pipe.sv
// N-way one-hot multiplexer for switch traversal: grant decode, AND-OR select,
// multi-hot error flag, and a two-entry skid buffer on the output.
module mux_onehot_pipe
    import mux_onehot_pipe_pkg::*;
#(
    parameter int NUM_PORTS  = 4,   // must be in [2, ONEHOT_MAX_WIDTH]
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            sel,
    input  logic [NUM_PORTS-1:0]            valid_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
    output logic [NUM_PORTS-1:0]            ready_o,
    output logic                            valid_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    input  logic                            ready_i,
    output logic                            sel_err_o
);

    logic [ONEHOT_MAX_WIDTH-1:0] sel_ext;
    logic                        sel_legal;
    logic                        sel_hot;
    logic                        up_rdy;
    logic                        sel_valid;
    logic [DATA_WIDTH-1:0]       sel_data;
    logic                        sel_err_q, sel_err_d;

    // Grant decode, per-channel ready and the AND-OR data select.
    always_comb begin
        sel_ext                 = '0;
        sel_ext[NUM_PORTS-1:0]  = sel;
        sel_legal               = onehot_legal(sel_ext);
        sel_hot                 = onehot_exact(sel_ext);

        ready_o   = sel & {NUM_PORTS{sel_hot & up_rdy}};
        sel_valid = sel_hot & (|(valid_i & sel));

        sel_data = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sel_data = sel_data | (data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel[k]}});
        end

        sel_err_d = (|sel) & ~sel_legal;
    end

    // Multi-hot grant flag, one pulse per bad cycle, independent of valid_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err_o = sel_err_q;

    skid_buffer_2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (sel_valid),
        .in_data_i   (sel_data),
        .in_ready_o  (up_rdy),
        .out_valid_o (valid_o),
        .out_data_o  (data_o),
        .out_ready_i (ready_i)
    );

endmodule : mux_onehot_pipe
